// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch unit.
// Issues sequential word fetches to a 1-cycle-latency synchronous ROM and
// buffers each returned instruction together with its byte PC in a small
// FIFO. The head entry is offered to the core under a valid/ready handshake.
// A redirect discards every queued and in-flight fetch and restarts fetching
// at the (word-aligned) target.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,             // FIFO entries, power of two, >= 2
    parameter logic [31:0] RESET_PC = 32'h0000_0000, // first fetch address after reset
    parameter int unsigned AW       = 14             // ROM word-address width
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          irom_en,
    output logic [AW-1:0] irom_addr,
    input  logic [31:0]   irom_rdata,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready
);

    localparam int unsigned PW = $clog2(DEPTH);

    // Occupancy limits: a fetch may only issue if the queue can still hold
    // its response, counting the word that is already on its way back.
    localparam logic [PW:0]   CNT_MAX    = (PW+1)'(DEPTH);
    localparam logic [PW:0]   CNT_MAX_M1 = (PW+1)'(DEPTH - 1);
    localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]   fetch_pc;     // byte PC of the next fetch to issue
    logic          inflight;     // a ROM read was issued last cycle
    logic [31:0]   inflight_pc;  // byte PC of that read

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic space_ok;
    logic issue;
    logic push;
    logic pop;
    logic has_entries;

    // The low two bits of the redirect target never reach the fetch PC.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    assign space_ok    = inflight ? (count < CNT_MAX_M1) : (count < CNT_MAX);
    assign issue       = !rst && !redirect_valid && space_ok;
    assign has_entries = (count != '0);

    // A ROM return is kept only if nothing has flushed it in this cycle.
    assign push = inflight && !rst && !redirect_valid;

    // A redirect cycle hides the head, so a concurrent out_ready is ignored.
    assign out_valid = !rst && !redirect_valid && has_entries;
    assign pop       = out_valid && out_ready;

    assign irom_en   = issue;
    assign irom_addr = fetch_pc[AW+1:2];

    // Head entry is read straight from the array; it is zeroed while invalid
    // so the outputs are well defined out of reset and during a flush.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : 32'h0000_0000;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'h0000_0000;

    // ------------------------------------------------------------------
    // Fetch sequencer: next PC, in-flight tracking, redirect restart
    // ------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0000_0000;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue bookkeeping: pointers and occupancy
    // ------------------------------------------------------------------
    // Redirect discards everything by snapping the read pointer onto the
    // write pointer; the storage itself is left as is.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Queue storage: write the returning {pc, instr} pair at the tail
    // ------------------------------------------------------------------
    // NOTE: the payload arrays carry no reset; an entry is only ever read
    // after it has been written, since count guards out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= irom_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Design invariants
    // ------------------------------------------------------------------
    // The reservation rule guarantees the queue never overfills.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (rst) (count <= CNT_MAX)
    );

    // A stalled head must hold until it is taken or flushed.
    a_head_stable : assert property (
        @(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
            (rst || redirect_valid || (out_valid && out_pc == $past(out_pc)
                                        && out_instr == $past(out_instr)))
    );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: self-checking bench for ifetch_queue.
// A behavioural model (a queue of pending PCs plus the fetch PC and one
// in-flight slot) predicts irom_en/irom_addr and the head of the output
// stream every cycle; scenario tasks add directed checks on top of it.
module tb_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned AW       = 14;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic          clk;
    logic          rst            = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc    = 32'h0;
    logic          irom_en;
    logic [AW-1:0] irom_addr;
    logic [31:0]   irom_rdata;
    logic          out_valid;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          out_ready      = 1'b0;

    int checks = 0;
    int errors = 0;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .AW       (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .irom_en        (irom_en),
        .irom_addr      (irom_addr),
        .irom_rdata     (irom_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .out_ready      (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: word k holds 0x1000_0000 + k.
    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + {{(32-AW){1'b0}}, a};
    endfunction

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        logic [AW-1:0] a;
        a = pc[AW+1:2];
        return rom_word(a);
    endfunction

    // Synchronous-read ROM with one cycle of latency.
    logic [31:0] rom_q;
    always @(posedge clk) begin
        if (irom_en) rom_q <= rom_word(irom_addr);
    end
    assign irom_rdata = rom_q;

    // ------------------------------------------------------------------
    // Reference model: pending PCs in order, one in-flight slot, fetch PC.
    // ------------------------------------------------------------------
    logic [31:0] mq[$];
    logic        m_infl     = 1'b0;
    logic [31:0] m_infl_pc  = 32'h0;
    logic [31:0] m_fetch_pc = RESET_PC;
    logic        m_en       = 1'b0;
    logic        m_valid    = 1'b0;

    // Predict this cycle's outputs and compare (inputs settle at negedge).
    always @(negedge clk) begin
        logic [31:0]   head;
        logic [AW-1:0] exp_addr;
        #2;
        m_en    = !rst && !redirect_valid && ((mq.size() + (m_infl ? 1 : 0)) < DEPTH);
        m_valid = !rst && !redirect_valid && (mq.size() != 0);
        checks++;
        if (irom_en !== m_en) begin
            errors++;
            $display("FAIL model_irom_en t=%0t got=%b exp=%b", $time, irom_en, m_en);
        end
        if (m_en) begin
            exp_addr = m_fetch_pc[AW+1:2];
            checks++;
            if (irom_addr !== exp_addr) begin
                errors++;
                $display("FAIL model_irom_addr t=%0t got=%h exp=%h", $time, irom_addr, exp_addr);
            end
        end
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL model_out_valid t=%0t got=%b exp=%b", $time, out_valid, m_valid);
        end
        if (m_valid) begin
            head = mq[0];
            checks++;
            if (out_pc !== head || out_instr !== instr_of(head)) begin
                errors++;
                $display("FAIL model_head t=%0t got pc=%h instr=%h exp pc=%h instr=%h",
                         $time, out_pc, out_instr, head, instr_of(head));
            end
        end
    end

    // Advance the model at each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_infl     = 1'b0;
            m_fetch_pc = RESET_PC;
        end else if (redirect_valid) begin
            mq.delete();
            m_infl     = 1'b0;
            m_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            if (m_valid && out_ready) void'(mq.pop_front());
            if (m_infl) mq.push_back(m_infl_pc);
            if (m_en) begin
                m_infl_pc  = m_fetch_pc;
                m_fetch_pc = m_fetch_pc + 32'd4;
                m_infl     = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge; return 3 time units later)
    // ------------------------------------------------------------------
    task automatic set_in(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        #3;
    endtask

    task automatic next_cyc();
        @(negedge clk);
    endtask

    task automatic reset_one();
        set_in(1'b1, 1'b0, 32'h0, 1'b0);
        next_cyc();
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            set_in(1'b1, 1'b0, 32'h0, 1'b1);
            checks++;
            if (irom_en !== 1'b0) begin
                errors++; $display("FAIL reset_irom_en got=%b exp=0", irom_en);
            end
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
            end
            checks++;
            if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
                errors++; $display("FAIL reset_head got pc=%h instr=%h exp 0/0", out_pc, out_instr);
            end
            next_cyc();
        end
    endtask

    task automatic test_stream();
        int first_en  = -1;
        int first_val = -1;
        int k = 0;
        for (int c = 0; c < 40; c++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            if (irom_en && first_en < 0) first_en = c;
            if (out_valid) begin
                if (first_val < 0) first_val = c;
                checks++;
                if (out_pc !== 32'(k * 4) || out_instr !== 32'h1000_0000 + 32'(k)) begin
                    errors++;
                    $display("FAIL stream_pair k=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                             k, out_pc, out_instr, 32'(k * 4), 32'h1000_0000 + 32'(k));
                end
                k++;
            end else if (first_val >= 0) begin
                checks++; errors++;
                $display("FAIL stream_gap cycle=%0d got valid=0 exp valid=1", c);
            end
            next_cyc();
        end
        checks++;
        if (first_en != 0 || first_val != 2) begin
            errors++;
            $display("FAIL stream_latency got en@%0d valid@%0d exp en@0 valid@2", first_en, first_val);
        end
        checks++;
        if (k != 38) begin
            errors++; $display("FAIL stream_count got=%0d exp=38", k);
        end
    endtask

    task automatic test_full();
        int pulses = 0;
        reset_one();
        for (int c = 0; c < 12; c++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b0);
            if (irom_en) pulses++;
            if (out_valid) begin
                checks++;
                if (out_pc !== 32'h0 || out_instr !== 32'h1000_0000) begin
                    errors++;
                    $display("FAIL full_head_hold got pc=%h instr=%h exp 0/10000000", out_pc, out_instr);
                end
            end
            next_cyc();
        end
        checks++;
        if (pulses != DEPTH) begin
            errors++; $display("FAIL full_pulses got=%0d exp=%0d", pulses, DEPTH);
        end
        // One-cycle pop: no fetch yet in the pop cycle.
        set_in(1'b0, 1'b0, 32'h0, 1'b1);
        checks++;
        if (irom_en !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL full_pop_cycle got en=%b valid=%b exp en=0 valid=1", irom_en, out_valid);
        end
        next_cyc();
        // Exactly one refill fetch (word 4) in the following cycle.
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (irom_en !== 1'b1 || irom_addr !== 14'h004) begin
            errors++; $display("FAIL full_refill got en=%b addr=%h exp en=1 addr=004", irom_en, irom_addr);
        end
        checks++;
        if (out_pc !== 32'h4) begin
            errors++; $display("FAIL full_next_head got pc=%h exp=00000004", out_pc);
        end
        next_cyc();
        set_in(1'b0, 1'b0, 32'h0, 1'b0);
        checks++;
        if (irom_en !== 1'b0) begin
            errors++; $display("FAIL full_single_refill got en=%b exp=0", irom_en);
        end
        next_cyc();
    endtask

    task automatic test_redirect();
        int first = -1;
        int k = 0;
        reset_one();
        // Four stalled cycles leave three entries queued and one in flight.
        for (int c = 0; c < 4; c++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b0);
            next_cyc();
        end
        set_in(1'b0, 1'b1, 32'h0000_0043, 1'b1);
        checks++;
        if (irom_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL redir_cycle got en=%b valid=%b exp 0/0", irom_en, out_valid);
        end
        next_cyc();
        for (int j = 0; j < 12; j++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            if (j == 0) begin
                checks++;
                if (irom_en !== 1'b1 || irom_addr !== 14'h010) begin
                    errors++; $display("FAIL redir_addr got en=%b addr=%h exp en=1 addr=010", irom_en, irom_addr);
                end
            end
            if (out_valid) begin
                if (first < 0) first = j;
                checks++;
                if (out_pc !== 32'h40 + 32'(4 * k) || out_instr !== rom_word(AW'(16 + k))) begin
                    errors++;
                    $display("FAIL redir_stream k=%0d got pc=%h instr=%h exp pc=%h", k, out_pc, out_instr,
                             32'h40 + 32'(4 * k));
                end
                k++;
            end
            next_cyc();
        end
        checks++;
        if (first != 2) begin
            errors++; $display("FAIL redir_latency got=%0d exp=2 (cycles after N+1)", first);
        end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int k = 0;
        reset_one();
        for (int c = 0; c < 5; c++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            next_cyc();
        end
        set_in(1'b0, 1'b1, 32'h0000_0100, 1'b1);
        checks++;
        if (irom_en !== 1'b0) begin
            errors++; $display("FAIL b2b_first_en got=%b exp=0", irom_en);
        end
        next_cyc();
        set_in(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        checks++;
        if (irom_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second got en=%b valid=%b exp 0/0", irom_en, out_valid);
        end
        next_cyc();
        for (int j = 0; j < 10; j++) begin
            set_in(1'b0, 1'b0, 32'h0, (j < 2) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (j == 0) begin
                checks++;
                if (irom_en !== 1'b1 || irom_addr !== 14'h080) begin
                    errors++; $display("FAIL b2b_addr got en=%b addr=%h exp en=1 addr=080", irom_en, irom_addr);
                end
            end
            if (out_valid) begin
                if (first < 0) first = j;
                checks++;
                if (out_pc !== 32'h200 + 32'(4 * k)) begin
                    errors++; $display("FAIL b2b_stream got pc=%h exp=%h", out_pc, 32'h200 + 32'(4 * k));
                end
                if (out_ready) k++;
            end
            next_cyc();
        end
        checks++;
        if (first != 2) begin
            errors++; $display("FAIL b2b_latency got=%0d exp=2", first);
        end
    endtask

    task automatic test_reset_mid();
        int first = -1;
        int k = 0;
        reset_one();
        for (int c = 0; c < 6; c++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
            next_cyc();
        end
        set_in(1'b1, 1'b0, 32'h0, 1'b1);
        checks++;
        if (irom_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_rst_cycle got en=%b valid=%b exp 0/0", irom_en, out_valid);
        end
        next_cyc();
        for (int j = 0; j < 8; j++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            if (j == 0) begin
                checks++;
                if (out_valid !== 1'b0 || irom_en !== 1'b1 || irom_addr !== 14'h000) begin
                    errors++;
                    $display("FAIL rmid_restart got valid=%b en=%b addr=%h exp valid=0 en=1 addr=000",
                             out_valid, irom_en, irom_addr);
                end
            end
            if (out_valid) begin
                if (first < 0) first = j;
                checks++;
                if (out_pc !== 32'(4 * k) || out_instr !== 32'h1000_0000 + 32'(k)) begin
                    errors++; $display("FAIL rmid_stream got pc=%h instr=%h exp pc=%h", out_pc, out_instr, 32'(4 * k));
                end
                k++;
            end
            next_cyc();
        end
        checks++;
        if (first != 2) begin
            errors++; $display("FAIL rmid_latency got=%0d exp=2", first);
        end
    endtask

    task automatic test_wrap();
        int k = 0;
        logic [31:0] exp_pc;
        set_in(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        next_cyc();
        for (int j = 0; j < 12; j++) begin
            set_in(1'b0, 1'b0, 32'h0, 1'b1);
            if (j == 0) begin
                checks++;
                if (irom_en !== 1'b1 || irom_addr !== 14'h3FFF) begin
                    errors++; $display("FAIL wrap_addr_top got en=%b addr=%h exp en=1 addr=3fff", irom_en, irom_addr);
                end
            end
            if (j == 1) begin
                checks++;
                if (irom_en !== 1'b1 || irom_addr !== 14'h0000) begin
                    errors++; $display("FAIL wrap_addr_zero got en=%b addr=%h exp en=1 addr=0000", irom_en, irom_addr);
                end
            end
            if (out_valid) begin
                exp_pc = 32'hFFFF_FFFC + 32'(4 * k);
                checks++;
                if (out_pc !== exp_pc || out_instr !== instr_of(exp_pc)) begin
                    errors++;
                    $display("FAIL wrap_stream got pc=%h instr=%h exp pc=%h instr=%h",
                             out_pc, out_instr, exp_pc, instr_of(exp_pc));
                end
                k++;
            end
            next_cyc();
        end
        checks++;
        if (k != 10) begin
            errors++; $display("FAIL wrap_count got=%0d exp=10", k);
        end
    endtask

    task automatic test_random();
        int pops = 0;
        logic r, rv, rdy;
        for (int c = 0; c < 400; c++) begin
            r   = ($urandom_range(0, 63) == 0);
            rv  = !r && ($urandom_range(0, 15) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            set_in(r, rv, $urandom, rdy);
            if (out_valid && out_ready) pops++;
            next_cyc();
        end
        checks++;
        if (pops < 50) begin
            errors++; $display("FAIL random_progress got pops=%0d exp>=50", pops);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_stream();
        test_full();
        test_redirect();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if the sequence above ever fails to complete.
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
